vreg_loader: RTL and testbench

VREG_LOADER -- requirements
Module: vreg_loader

---
 rtl/vreg_loader_pkg.sv | 21 ++
 rtl/vreg_loader.sv | 205 ++++++++++++++++++++
 tb/tb_vreg_loader.sv | 343 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/vreg_loader_pkg.sv
// ---------------------------------------------------------------------------
// vreg_loader_pkg
//   Shared definitions for the vector-register loader: stream word width,
//   default register-file geometry and the loader state encoding.
// ---------------------------------------------------------------------------
package vreg_loader_pkg;

  // Width of one stream word and of one register lane.
  localparam int WORD_W    = 32;

  // Default geometry: 4 vector registers of 16 x 32-bit lanes (512 bits).
  localparam int DEF_NREGS = 4;
  localparam int DEF_LANES = 16;

  // Loader states.
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_LOAD = 1'b1
  } state_e;

endpackage : vreg_loader_pkg

// File: rtl/vreg_loader.sv
// ---------------------------------------------------------------------------
// vreg_loader
//   Streams NREGS*LANES 32-bit words into a vector register file, one lane
//   per accepted word, in register-major / lane-minor order (A1 lane 0 first;
//   lane 0 is the most significant 32 bits of a register).
//
//   Optional feature, enabled by defining VREG_LOADER_CHECKSUM_EN:
//     A trailer word follows the last data word. It is compared with the
//     modulo-2^32 sum of the data words; a mismatch raises csum_err, which
//     stays high until the next start or reset. The trailer is never written.
//
// Ports
//   clock     in   rising-edge clock
//   reset_n   in   asynchronous active-low reset
//   start     in   one-cycle load request (ignored while a load is running)
//   in_data   in   stream word
//   in_valid  in   in_data is valid
//   in_ready  out  loader accepts a word (high only while loading)
//   wr_en     out  lane write strobe, one cycle after each accepted data word
//   wr_reg    out  target register index (0 = A1)
//   wr_lane   out  target lane index
//   wr_data   out  lane write data
//   busy      out  load in progress
//   csum_err  out  checksum mismatch (only with VREG_LOADER_CHECKSUM_EN)
//   done      out  one-cycle completion pulse
// ---------------------------------------------------------------------------
module vreg_loader
  import vreg_loader_pkg::*;
#(
  parameter  int NREGS  = DEF_NREGS,
  parameter  int LANES  = DEF_LANES,
  localparam int REG_W  = (NREGS > 1) ? $clog2(NREGS) : 1,
  localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              start,
  input  logic [WORD_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              wr_en,
  output logic [REG_W-1:0]  wr_reg,
  output logic [LANE_W-1:0] wr_lane,
  output logic [WORD_W-1:0] wr_data,
  output logic              busy,
`ifdef VREG_LOADER_CHECKSUM_EN
  output logic              csum_err,
`endif
  output logic              done
);

  localparam logic [REG_W-1:0]  REG_LAST  = REG_W'(NREGS - 1);
  localparam logic [LANE_W-1:0] LANE_LAST = LANE_W'(LANES - 1);

  state_e              state_q,     state_d;
  logic [REG_W-1:0]    reg_cnt_q,   reg_cnt_d;
  logic [LANE_W-1:0]   lane_cnt_q,  lane_cnt_d;
  logic                wr_en_q,     wr_en_d;
  logic [REG_W-1:0]    wr_reg_q,    wr_reg_d;
  logic [LANE_W-1:0]   wr_lane_q,   wr_lane_d;
  logic [WORD_W-1:0]   wr_data_q,   wr_data_d;
  logic                done_q,      done_d;

  logic                xfer;        // handshake completes at the next edge
  logic                data_xfer;   // handshake carries a data (not trailer) word
  logic                last_word;   // counters point at the final data word

`ifdef VREG_LOADER_CHECKSUM_EN
  logic                trailer_q,   trailer_d;   // waiting for the trailer word
  logic [WORD_W-1:0]   sum_q,       sum_d;
  logic                csum_err_q,  csum_err_d;
`endif

  // -------------------------------------------------------------------------
  // Next-state and datapath logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    reg_cnt_d  = reg_cnt_q;
    lane_cnt_d = lane_cnt_q;
    wr_en_d    = 1'b0;
    wr_reg_d   = wr_reg_q;
    wr_lane_d  = wr_lane_q;
    wr_data_d  = wr_data_q;
    done_d     = 1'b0;
`ifdef VREG_LOADER_CHECKSUM_EN
    trailer_d  = trailer_q;
    sum_d      = sum_q;
    csum_err_d = csum_err_q;
`endif

    xfer      = in_valid && (state_q == ST_LOAD);
    last_word = (reg_cnt_q == REG_LAST) && (lane_cnt_q == LANE_LAST);
`ifdef VREG_LOADER_CHECKSUM_EN
    data_xfer = xfer && !trailer_q;
`else
    data_xfer = xfer;
`endif

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_LOAD;
`ifdef VREG_LOADER_CHECKSUM_EN
          trailer_d  = 1'b0;
          sum_d      = '0;
          csum_err_d = 1'b0;
`endif
        end
      end

      ST_LOAD: begin
        if (data_xfer) begin
          // Register the lane write; it appears on the outputs next cycle.
          wr_en_d   = 1'b1;
          wr_reg_d  = reg_cnt_q;
          wr_lane_d = lane_cnt_q;
          wr_data_d = in_data;
`ifdef VREG_LOADER_CHECKSUM_EN
          sum_d     = sum_q + in_data;
`endif
          if (last_word) begin
            // Counters wrap here so the next load always starts at A1 lane 0.
            reg_cnt_d  = '0;
            lane_cnt_d = '0;
`ifdef VREG_LOADER_CHECKSUM_EN
            trailer_d  = 1'b1;
`else
            state_d    = ST_IDLE;
            done_d     = 1'b1;
`endif
          end else if (lane_cnt_q == LANE_LAST) begin
            lane_cnt_d = '0;
            reg_cnt_d  = reg_cnt_q + 1'b1;
          end else begin
            lane_cnt_d = lane_cnt_q + 1'b1;
          end
        end
`ifdef VREG_LOADER_CHECKSUM_EN
        if (xfer && trailer_q) begin
          // Trailer: compare only, no lane write.
          trailer_d  = 1'b0;
          csum_err_d = (in_data != sum_q);
          state_d    = ST_IDLE;
          done_d     = 1'b1;
        end
`endif
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // State and output registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      reg_cnt_q  <= '0;
      lane_cnt_q <= '0;
      wr_en_q    <= 1'b0;
      wr_reg_q   <= '0;
      wr_lane_q  <= '0;
      wr_data_q  <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      reg_cnt_q  <= reg_cnt_d;
      lane_cnt_q <= lane_cnt_d;
      wr_en_q    <= wr_en_d;
      wr_reg_q   <= wr_reg_d;
      wr_lane_q  <= wr_lane_d;
      wr_data_q  <= wr_data_d;
      done_q     <= done_d;
    end
  end

`ifdef VREG_LOADER_CHECKSUM_EN
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      trailer_q  <= 1'b0;
      sum_q      <= '0;
      csum_err_q <= 1'b0;
    end else begin
      trailer_q  <= trailer_d;
      sum_q      <= sum_d;
      csum_err_q <= csum_err_d;
    end
  end

  assign csum_err = csum_err_q;
`endif

  // Handshake and status come straight from the state register.
  assign in_ready = (state_q == ST_LOAD);
  assign busy     = (state_q == ST_LOAD);

  assign wr_en    = wr_en_q;
  assign wr_reg   = wr_reg_q;
  assign wr_lane  = wr_lane_q;
  assign wr_data  = wr_data_q;
  assign done     = done_q;

endmodule : vreg_loader

// File: tb/tb_vreg_loader.sv
// ---------------------------------------------------------------------------
// tb_vreg_loader
//   Directed bench for vreg_loader. A transaction-level model predicts every
//   output from the word index of each accepted transfer; a compare process
//   checks the DUT against it every cycle, and literal expectations pin the
//   key write addresses, load spans and reset values.
// ---------------------------------------------------------------------------
module tb_vreg_loader;

  localparam int NREGS = 4;
  localparam int LANES = 16;
  localparam int TOTAL = NREGS * LANES;

  logic        clock;
  logic        reset_n;
  logic        start;
  logic [31:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic        wr_en;
  logic [1:0]  wr_reg;
  logic [3:0]  wr_lane;
  logic [31:0] wr_data;
  logic        busy;
  logic        done;
`ifdef VREG_LOADER_CHECKSUM_EN
  logic        csum_err;
`endif

  vreg_loader #(.NREGS(NREGS), .LANES(LANES)) dut (
    .clock    (clock),
    .reset_n  (reset_n),
    .start    (start),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .wr_en    (wr_en),
    .wr_reg   (wr_reg),
    .wr_lane  (wr_lane),
    .wr_data  (wr_data),
    .busy     (busy),
`ifdef VREG_LOADER_CHECKSUM_EN
    .csum_err (csum_err),
`endif
    .done     (done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %08h expected %08h", name, act, exp);
  endtask

  // ---------------------------------------------------------------------
  // Transaction model: word k of a load goes to register k/LANES, lane
  // k%LANES, visible one cycle after the accepting edge.
  // ---------------------------------------------------------------------
  logic        m_busy, m_wr_en, m_done;
  logic [1:0]  m_reg;
  logic [3:0]  m_lane;
  logic [31:0] m_data;
  int          m_cnt;
`ifdef VREG_LOADER_CHECKSUM_EN
  logic        m_trailer, m_csum;
  logic [31:0] m_sum;
`endif

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      m_busy <= 0; m_wr_en <= 0; m_done <= 0;
      m_reg <= 0; m_lane <= 0; m_data <= 0; m_cnt <= 0;
`ifdef VREG_LOADER_CHECKSUM_EN
      m_trailer <= 0; m_csum <= 0; m_sum <= 0;
`endif
    end else begin
      m_wr_en <= 0;
      m_done  <= 0;
      if (!m_busy) begin
        if (start) begin
          m_busy <= 1;
`ifdef VREG_LOADER_CHECKSUM_EN
          m_sum <= 0; m_csum <= 0; m_trailer <= 0;
`endif
        end
      end else if (in_valid) begin
`ifdef VREG_LOADER_CHECKSUM_EN
        if (m_trailer) begin
          m_trailer <= 0;
          m_busy    <= 0;
          m_done    <= 1;
          m_csum    <= (in_data != m_sum);
        end else begin
          m_wr_en <= 1;
          m_reg   <= 2'(m_cnt / LANES);
          m_lane  <= 4'(m_cnt % LANES);
          m_data  <= in_data;
          m_sum   <= m_sum + in_data;
          if (m_cnt == TOTAL - 1) begin m_cnt <= 0; m_trailer <= 1; end
          else m_cnt <= m_cnt + 1;
        end
`else
        m_wr_en <= 1;
        m_reg   <= 2'(m_cnt / LANES);
        m_lane  <= 4'(m_cnt % LANES);
        m_data  <= in_data;
        if (m_cnt == TOTAL - 1) begin m_cnt <= 0; m_busy <= 0; m_done <= 1; end
        else m_cnt <= m_cnt + 1;
`endif
      end
    end
  end

  // Per-cycle comparison against the model.
  bit checking = 0;
  always @(negedge clock) begin
    if (checking) begin
      chk("in_ready", in_ready, m_busy);
      chk("busy",     busy,     m_busy);
      chk("wr_en",    wr_en,    m_wr_en);
      chk("done",     done,     m_done);
      chk("wr_reg",   wr_reg,   m_reg);
      chk("wr_lane",  wr_lane,  m_lane);
      chk("wr_data",  wr_data,  m_data);
`ifdef VREG_LOADER_CHECKSUM_EN
      chk("csum_err", csum_err, m_csum);
`endif
    end
  end

  // Write log and activity counters for the literal checks.
  logic [1:0]  log_reg  [0:1023];
  logic [3:0]  log_lane [0:1023];
  logic [31:0] log_data [0:1023];
  int          log_n = 0;
  int          busy_cnt = 0;
  logic        done_with_wr = 0;

  always @(negedge clock) begin
    if (wr_en === 1'b1 && log_n < 1024) begin
      log_reg[log_n]  = wr_reg;
      log_lane[log_n] = wr_lane;
      log_data[log_n] = wr_data;
      log_n++;
    end
    if (busy === 1'b1) busy_cnt++;
    if (done === 1'b1) begin
      done_with_wr = wr_en;
      $display("load done at %0t (writes logged %0d)", $time, log_n);
    end
  end

  // ---------------------------------------------------------------------
  // Stimulus helpers (inputs change on the falling edge)
  // ---------------------------------------------------------------------
  logic [31:0] feed_sum;

  task automatic send_word(input logic [31:0] d, input bit st);
    in_valid = 1; in_data = d; start = st;
    @(negedge clock);
    in_valid = 0; start = 0;
  endtask

  task automatic start_pulse();
    start = 1; feed_sum = 0;
    @(negedge clock);
    start = 0;
  endtask

  task automatic feed(input int n, input logic [31:0] base, input bit cmode,
                      input bit gaps, input int start_at);
    for (int i = 0; i < n; i++) begin
      logic [31:0] d;
      d = cmode ? base : base + 32'(i);
      feed_sum = feed_sum + d;
      send_word(d, i == start_at);
      if (gaps && i != n - 1) @(negedge clock);
    end
  endtask

  task automatic finish_load(input bit gaps);
`ifdef VREG_LOADER_CHECKSUM_EN
    if (gaps) @(negedge clock);
    send_word(feed_sum, 0);
`else
    if (gaps) feed_sum = feed_sum;
`endif
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clock);
    #1;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_in_ready"}, in_ready, 0);
    chk({tag, "_busy"},     busy,     0);
    chk({tag, "_wr_en"},    wr_en,    0);
    chk({tag, "_done"},     done,     0);
    chk({tag, "_wr_reg"},   wr_reg,   0);
    chk({tag, "_wr_lane"},  wr_lane,  0);
    chk({tag, "_wr_data"},  wr_data,  0);
  endtask

`ifdef VREG_LOADER_CHECKSUM_EN
  localparam int EXTRA = 1;   // trailer cycle inside busy
`else
  localparam int EXTRA = 0;
`endif

  int b, bc;

  initial begin
    reset_n = 1; start = 0; in_valid = 0; in_data = 0; feed_sum = 0;
    #2 reset_n = 0;
    #1 chk_reset_vals("reset");
    repeat (2) @(negedge clock);
    reset_n = 1;
    checking = 1;
    @(negedge clock);

    // T1: 64 incrementing words, in_valid always high.
    b = log_n; bc = busy_cnt;
    start_pulse();
    feed(TOTAL, 32'h0, 0, 0, -1);
    finish_load(0);
    idle(3);
    chk("t1_writes",   log_n - b, 64);
    chk("t1_w16_reg",  log_reg[b+16],  1);
    chk("t1_w16_lane", log_lane[b+16], 0);
    chk("t1_w16_data", log_data[b+16], 32'h10);
    chk("t1_w63_reg",  log_reg[b+63],  3);
    chk("t1_w63_lane", log_lane[b+63], 15);
    chk("t1_w63_data", log_data[b+63], 32'h3F);
    chk("t1_busy_cycles", busy_cnt - bc, 64 + EXTRA);
    chk("t1_done_with_wr", done_with_wr, (EXTRA == 0) ? 1 : 0);
    $display("T1 checked: writes %0d busy %0d", log_n - b, busy_cnt - bc);

    // T2: same stream, in_valid low every other cycle.
    b = log_n; bc = busy_cnt;
    @(negedge clock);
    start_pulse();
    feed(TOTAL, 32'h0, 0, 1, -1);
    finish_load(1);
    idle(3);
    chk("t2_writes",   log_n - b, 64);
    chk("t2_w16_reg",  log_reg[b+16], 1);
    chk("t2_w63_lane", log_lane[b+63], 15);
    chk("t2_w63_data", log_data[b+63], 32'h3F);
    chk("t2_busy_cycles", busy_cnt - bc, 127 + 2 * EXTRA);
    $display("T2 checked: writes %0d busy %0d", log_n - b, busy_cnt - bc);

    // T3: start pulsed with word 20 is ignored.
    b = log_n;
    start_pulse();
    feed(TOTAL, 32'h0, 0, 0, 20);
    finish_load(0);
    idle(3);
    chk("t3_writes",   log_n - b, 64);
    chk("t3_w20_reg",  log_reg[b+20],  1);
    chk("t3_w20_lane", log_lane[b+20], 4);
    chk("t3_w20_data", log_data[b+20], 32'h14);
    $display("T3 checked: writes %0d", log_n - b);

    // T4: reset after word 30, then a fresh constant-pattern load.
    start_pulse();
    feed(31, 32'h0, 0, 0, -1);
    @(posedge clock);
    #2 reset_n = 0;
    #1 chk_reset_vals("midreset");
    repeat (2) @(negedge clock);
    reset_n = 1;
    idle(1);
    b = log_n;
    @(negedge clock);
    start_pulse();
    feed(TOTAL, 32'hA5A5A5A5, 1, 0, -1);
    finish_load(0);
    idle(3);
    chk("t4_writes",   log_n - b, 64);
    chk("t4_w0_reg",   log_reg[b],  0);
    chk("t4_w0_lane",  log_lane[b], 0);
    chk("t4_w0_data",  log_data[b], 32'hA5A5A5A5);
    $display("T4 checked: writes %0d", log_n - b);

    // T5: start in the done cycle begins the next load with no gap.
    b = log_n;
    @(negedge clock);
    start_pulse();
    feed(TOTAL, 32'h0, 0, 0, -1);
    finish_load(0);
    chk("t5_done_cycle", done, 1);
    start_pulse();
    chk("t5_busy_next", busy, 1);
    feed(TOTAL, 32'h100, 0, 0, -1);
    finish_load(0);
    idle(3);
    chk("t5_writes",    log_n - b, 128);
    chk("t5_w64_reg",   log_reg[b+64],  0);
    chk("t5_w64_lane",  log_lane[b+64], 0);
    chk("t5_w64_data",  log_data[b+64], 32'h100);
    chk("t5_w127_reg",  log_reg[b+127], 3);
    chk("t5_w127_data", log_data[b+127], 32'h13F);
    $display("T5 checked: writes %0d", log_n - b);

`ifdef VREG_LOADER_CHECKSUM_EN
    // T6: words 1..64 sum to 0x820.
    b = log_n;
    @(negedge clock);
    start_pulse();
    feed(TOTAL, 32'h1, 0, 0, -1);
    send_word(32'h820, 0);
    idle(3);
    chk("t6_csum_ok",  csum_err, 0);
    chk("t6_writes",   log_n - b, 64);
    b = log_n;
    @(negedge clock);
    start_pulse();
    feed(TOTAL, 32'h1, 0, 0, -1);
    send_word(32'h821, 0);
    idle(3);
    chk("t6_csum_bad", csum_err, 1);
    chk("t6_no_65th",  log_n - b, 64);
    $display("T6 checked: csum_err %0b", csum_err);
`endif

    checking = 0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule : tb_vreg_loader
